// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
// Default geometry: x0-x31 plus q0-q3, two read ports.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 36;
    localparam int NRD_DEF   = 2;
    localparam int ZERO_REG  = 0;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_sel_t;

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port: select mux, optional write bypass, output flops.
// Bypass is compiled in with REGFILE_MP_BYPASS_EN.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset_ni,
`ifdef REGFILE_MP_BYPASS_EN
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_sel_i,
    input  logic [XLEN-1:0]       wr_data_i,
    input  logic                  rsv_en_i,
    input  logic [AW-1:0]         rsv_sel_i,
`endif
    input  logic [NREGS*XLEN-1:0] regs_i,
    input  logic [NREGS-1:0]      busy_i,
    input  logic                  rd_en_i,
    input  logic [AW-1:0]         rd_sel_i,
    output logic [XLEN-1:0]       rd_data_o,
    output logic                  rd_valid_o
);

    logic [XLEN-1:0] sel_data;
    logic            sel_busy;
    logic [XLEN-1:0] rd_data_d, rd_data_q;
    logic            rd_valid_d, rd_valid_q;
`ifdef REGFILE_MP_BYPASS_EN
    logic            sel_live;
`endif

    // Select the addressed register; out-of-range selects read as 0, not busy
    always_comb begin
        sel_data = '0;
        sel_busy = 1'b0;
`ifdef REGFILE_MP_BYPASS_EN
        sel_live = 1'b0;
`endif
        for (int r = 0; r < NREGS; r++) begin
            if (rd_sel_i == AW'(r)) begin
                sel_data = regs_i[r*XLEN +: XLEN];
                sel_busy = busy_i[r];
`ifdef REGFILE_MP_BYPASS_EN
                sel_live = (r != ZERO_REG);
`endif
            end
        end
    end

    // Next output: load on read request, else hold
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        if (rd_en_i) begin
            rd_data_d  = sel_data;
            rd_valid_d = !sel_busy;
`ifdef REGFILE_MP_BYPASS_EN
            if (wr_en_i && sel_live && wr_sel_i == rd_sel_i) begin
                rd_data_d  = wr_data_i;
                rd_valid_d = !(rsv_en_i && rsv_sel_i == rd_sel_i);
            end
`endif
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with producer scoreboard and debug read.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data to reads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset_ni,
    input  logic                 wr_en_i,
    input  logic [AW-1:0]        wr_sel_i,
    input  logic [XLEN-1:0]      wr_data_i,
    input  logic                 rsv_en_i,
    input  logic [AW-1:0]        rsv_sel_i,
    input  logic [NRD-1:0]       rd_en_i,
    input  logic [NRD*AW-1:0]    rd_sel_i,
    output logic [NRD*XLEN-1:0]  rd_data_o,
    output logic [NRD-1:0]       rd_valid_o,
    output logic [NREGS-1:0]     busy_o,
    input  logic [AW-1:0]        dbg_sel_i,
    output logic [XLEN-1:0]      dbg_data_o
);

    logic [XLEN-1:0]       regs_q [NREGS];
    logic [XLEN-1:0]       regs_d [NREGS];
    logic [NREGS-1:0]      busy_q, busy_d;
    logic [NREGS*XLEN-1:0] regs_flat;

    // Write-back and reservation; a same-cycle reserve keeps busy set
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int r = 0; r < NREGS; r++) begin
            if (r != ZERO_REG) begin
                if (wr_en_i && wr_sel_i == AW'(r)) begin
                    regs_d[r] = wr_data_i;
                    busy_d[r] = 1'b0;
                end
                if (rsv_en_i && rsv_sel_i == AW'(r)) begin
                    busy_d[r] = 1'b1;
                end
            end
        end
        regs_d[ZERO_REG] = '0;
        busy_d[ZERO_REG] = 1'b0;
    end

    // Register array and scoreboard state
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Flatten for the read ports and serve the debug read
    always_comb begin
        regs_flat  = '0;
        dbg_data_o = '0;
        for (int r = 0; r < NREGS; r++) begin
            regs_flat[r*XLEN +: XLEN] = regs_q[r];
            if (dbg_sel_i == AW'(r)) begin
                dbg_data_o = regs_q[r];
            end
        end
    end

    assign busy_o = busy_q;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        regfile_rdport #(
            .XLEN  (XLEN),
            .NREGS (NREGS)
        ) u_rdport (
            .clk        (clk),
            .reset_ni   (reset_ni),
`ifdef REGFILE_MP_BYPASS_EN
            .wr_en_i    (wr_en_i),
            .wr_sel_i   (wr_sel_i),
            .wr_data_i  (wr_data_i),
            .rsv_en_i   (rsv_en_i),
            .rsv_sel_i  (rsv_sel_i),
`endif
            .regs_i     (regs_flat),
            .busy_i     (busy_q),
            .rd_en_i    (rd_en_i[p]),
            .rd_sel_i   (rd_sel_i[p*AW +: AW]),
            .rd_data_o  (rd_data_o[p*XLEN +: XLEN]),
            .rd_valid_o (rd_valid_o[p])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed vector bench for regfile_mp (two read ports, 36 registers).
// Expectations follow REGFILE_MP_BYPASS_EN when it is defined.
module tb_regfile_mp;
    import regfile_pkg::*;

`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        wr_en_i;
    reg_sel_t    wr_sel_i;
    logic [31:0] wr_data_i;
    logic        rsv_en_i;
    reg_sel_t    rsv_sel_i;
    logic [1:0]  rd_en_i;
    logic [11:0] rd_sel_i;
    logic [63:0] rd_data_o;
    logic [1:0]  rd_valid_o;
    logic [35:0] busy_o;
    reg_sel_t    dbg_sel_i;
    logic [31:0] dbg_data_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk        (clk),
        .reset_ni   (reset_ni),
        .wr_en_i    (wr_en_i),
        .wr_sel_i   (wr_sel_i),
        .wr_data_i  (wr_data_i),
        .rsv_en_i   (rsv_en_i),
        .rsv_sel_i  (rsv_sel_i),
        .rd_en_i    (rd_en_i),
        .rd_sel_i   (rd_sel_i),
        .rd_data_o  (rd_data_o),
        .rd_valid_o (rd_valid_o),
        .busy_o     (busy_o),
        .dbg_sel_i  (dbg_sel_i),
        .dbg_data_o (dbg_data_o)
    );

    typedef struct {
        logic        wen;
        reg_sel_t    wsel;
        logic [31:0] wdata;
        logic        ren;
        reg_sel_t    rsel;
        logic [1:0]  rd;
        reg_sel_t    s0;
        reg_sel_t    s1;
        reg_sel_t    dsel;
        logic [31:0] d0;
        logic        v0;
        logic [31:0] d1;
        logic        v1;
        logic [35:0] busy;
        logic [31:0] dbg;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic wen, input int wsel, input logic [31:0] wdata,
        input logic ren, input int rsel,
        input logic [1:0] rd, input int s0, input int s1, input int dsel,
        input logic [31:0] d0, input logic v0,
        input logic [31:0] d1, input logic v1,
        input logic [35:0] busy, input logic [31:0] dbg);
        vec_t v;
        v.wen = wen;   v.wsel = reg_sel_t'(wsel); v.wdata = wdata;
        v.ren = ren;   v.rsel = reg_sel_t'(rsel);
        v.rd = rd;     v.s0 = reg_sel_t'(s0);     v.s1 = reg_sel_t'(s1);
        v.dsel = reg_sel_t'(dsel);
        v.d0 = d0; v.v0 = v0; v.d1 = d1; v.v1 = v1;
        v.busy = busy; v.dbg = dbg;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        wr_en_i   = v.wen;
        wr_sel_i  = v.wsel;
        wr_data_i = v.wdata;
        rsv_en_i  = v.ren;
        rsv_sel_i = v.rsel;
        rd_en_i   = v.rd;
        rd_sel_i  = {v.s1, v.s0};
        dbg_sel_i = v.dsel;
    endtask

    localparam logic [35:0] B7  = 36'h80;
    localparam logic [35:0] B9  = 36'h200;
    localparam logic [35:0] B96 = 36'h240;

    initial begin
        // wen wsel wdata  ren rsel  rd s0 s1 dsel  d0 v0 d1 v1  busy dbg
        vecs[0]  = mk(1, 5, 32'h1234_5678, 0, 0, 2'b00, 0, 0, 5,
                      0, 0, 0, 0, 0, 32'h1234_5678);
        vecs[1]  = mk(0, 0, 0, 0, 0, 2'b01, 5, 0, 5,
                      32'h1234_5678, 1, 0, 0, 0, 32'h1234_5678);
        vecs[2]  = mk(1, 0, 32'hFFFF_FFFF, 0, 0, 2'b00, 0, 0, 0,
                      32'h1234_5678, 1, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 2'b11, 0, 0, 0,
                      0, 1, 0, 1, 0, 0);
        vecs[4]  = mk(0, 0, 0, 1, 7, 2'b00, 0, 0, 7,
                      0, 1, 0, 1, B7, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 2'b11, 7, 5, 5,
                      0, 0, 32'h1234_5678, 1, B7, 32'h1234_5678);
        vecs[6]  = mk(1, 7, 32'hA5, 0, 0, 2'b00, 0, 0, 7,
                      0, 0, 32'h1234_5678, 1, 0, 32'hA5);
        vecs[7]  = mk(0, 0, 0, 0, 0, 2'b11, 7, 7, 7,
                      32'hA5, 1, 32'hA5, 1, 0, 32'hA5);
        vecs[8]  = mk(1, 3, 32'h55, 0, 0, 2'b11, 3, 40, 3,
                      BYP ? 32'h55 : 32'h0, 1, 0, 1, 0, 32'h55);
        vecs[9]  = mk(0, 0, 0, 0, 0, 2'b10, 0, 3, 3,
                      BYP ? 32'h55 : 32'h0, 1, 32'h55, 1, 0, 32'h55);
        vecs[10] = mk(1, 9, 32'h9999, 1, 9, 2'b00, 0, 0, 9,
                      BYP ? 32'h55 : 32'h0, 1, 32'h55, 1, B9, 32'h9999);
        vecs[11] = mk(0, 0, 0, 0, 0, 2'b01, 9, 0, 9,
                      32'h9999, 0, 32'h55, 1, B9, 32'h9999);
        vecs[12] = mk(1, 50, 32'hDEAD, 1, 50, 2'b00, 0, 0, 50,
                      32'h9999, 0, 32'h55, 1, B9, 0);
        vecs[13] = mk(0, 0, 0, 1, 0, 2'b01, 50, 0, 0,
                      0, 1, 32'h55, 1, B9, 0);
        vecs[14] = mk(1, 6, 32'h66, 1, 6, 2'b01, 6, 0, 6,
                      BYP ? 32'h66 : 32'h0, !BYP, 32'h55, 1, B96, 32'h66);
        vecs[15] = mk(0, 0, 0, 0, 0, 2'b11, 6, 9, 6,
                      32'h66, 0, 32'h9999, 0, B96, 32'h66);
        vecs[16] = mk(1, 6, 32'h7, 0, 0, 2'b01, 6, 0, 6,
                      BYP ? 32'h7 : 32'h66, BYP, 32'h9999, 0, B9, 32'h7);
        vecs[17] = mk(1, 35, 32'h3535_3535, 0, 0, 2'b10, 0, 35, 35,
                      BYP ? 32'h7 : 32'h66, BYP,
                      BYP ? 32'h3535_3535 : 32'h0, 1, B9, 32'h3535_3535);
        vecs[18] = mk(0, 0, 0, 0, 0, 2'b11, 35, 36, 35,
                      32'h3535_3535, 1, 0, 1, B9, 32'h3535_3535);

        reset_ni = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(negedge clk);
        reset_ni = 1'b1;
        #1;
        chk("reset.data", rd_data_o, 64'h0);
        chk("reset.valid", {62'h0, rd_valid_o}, 64'h0);
        chk("reset.busy", {28'h0, busy_o}, 64'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.data0", i), {32'h0, rd_data_o[31:0]},
                {32'h0, vecs[i].d0});
            chk($sformatf("v%0d.valid0", i), {63'h0, rd_valid_o[0]},
                {63'h0, vecs[i].v0});
            chk($sformatf("v%0d.data1", i), {32'h0, rd_data_o[63:32]},
                {32'h0, vecs[i].d1});
            chk($sformatf("v%0d.valid1", i), {63'h0, rd_valid_o[1]},
                {63'h0, vecs[i].v1});
            chk($sformatf("v%0d.busy", i), {28'h0, busy_o},
                {28'h0, vecs[i].busy});
            chk($sformatf("v%0d.dbg", i), {32'h0, dbg_data_o},
                {32'h0, vecs[i].dbg});
        end

        // Reset asserted in the middle of a read stream
        @(negedge clk);
        drive(mk(1, 4, 32'h99, 1, 11, 2'b00, 0, 0, 4,
                 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 2'b11, 4, 4, 4,
                 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("rst.pre.data", rd_data_o, {32'h99, 32'h99});
        chk("rst.pre.valid", {62'h0, rd_valid_o}, 64'h3);
        chk("rst.pre.busy11", {63'h0, busy_o[11]}, 64'h1);
        #2;
        reset_ni = 1'b0;
        #1;
        chk("rst.data", rd_data_o, 64'h0);
        chk("rst.valid", {62'h0, rd_valid_o}, 64'h0);
        chk("rst.busy", {28'h0, busy_o}, 64'h0);
        chk("rst.dbg", {32'h0, dbg_data_o}, 64'h0);
        @(negedge clk);
        reset_ni = 1'b1;
        @(posedge clk);
        #1;
        chk("post.data", rd_data_o, 64'h0);
        chk("post.valid", {62'h0, rd_valid_o}, 64'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
